// File: rtl/q_learn_pkg.sv
// Shared types and constants for the tic-tac-toe Q-learning datapath.
// Used by the max-Q scanner, the update stage and the epsilon-greedy selector.
package q_learn_pkg;

  localparam int Q_W       = 8;
  localparam int N_ACTIONS = 9;
  localparam int ADDR_W    = 10;
  localparam int ACT_W     = 4;

  localparam logic [ACT_W-1:0] NO_ACTION   = 4'hF;
  localparam logic [ACT_W-1:0] LAST_ACTION = 4'(N_ACTIONS - 1);

  typedef logic [Q_W-1:0] q_val_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

endpackage

// File: rtl/q_max_cmp.sv
// Compare-select step of a running argmax over Q-values.
// The first legal candidate always wins; later ones need a strictly greater value, so ties keep the lowest index.
module q_max_cmp
  import q_learn_pkg::*;
(
  input  logic [Q_W-1:0]   run_max_i,
  input  logic [ACT_W-1:0] run_idx_i,
  input  logic [Q_W-1:0]   cand_val_i,
  input  logic [ACT_W-1:0] cand_idx_i,
  input  logic             cand_legal_i,
  output logic [Q_W-1:0]   new_max_o,
  output logic [ACT_W-1:0] new_idx_o
);

  logic take_s;

  // Select the candidate or keep the running pair.
  always_comb begin
    take_s    = cand_legal_i && ((run_idx_i == NO_ACTION) || (cand_val_i > run_max_i));
    new_max_o = run_max_i;
    new_idx_o = run_idx_i;
    if (take_s) begin
      new_max_o = cand_val_i;
      new_idx_o = cand_idx_i;
    end else begin
      new_max_o = run_max_i;
      new_idx_o = run_idx_i;
    end
  end

endmodule

// File: rtl/q_max_scanner.sv
// Scans one Q-table row (cells 0..8) and reports the max Q over legal cells and its argmax.
// Reads are issued for every cell so the start-to-done latency is fixed at N_ACTIONS+2 cycles.
module q_max_scanner
  import q_learn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] state_base,
  input  logic [N_ACTIONS-1:0] legal_mask,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [Q_W-1:0]    rd_data,
  output logic              busy,
  output logic              done,
  output logic [Q_W-1:0]    max_Q,
  output logic [ACT_W-1:0]  best_action,
  output logic              no_legal
);

  scan_state_e            state_q, state_d;
  logic [N_ACTIONS-1:0]   mask_q, mask_d;
  logic [ACT_W-1:0]       k_q, k_d;
  logic                   rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   cmp_vld_q, cmp_vld_d;
  logic [ACT_W-1:0]       cmp_idx_q, cmp_idx_d;
  logic [Q_W-1:0]         run_max_q, run_max_d;
  logic [ACT_W-1:0]       run_idx_q, run_idx_d;
  logic [Q_W-1:0]         res_max_q, res_max_d;
  logic [ACT_W-1:0]       res_idx_q, res_idx_d;
  logic                   res_nl_q, res_nl_d;

  logic                   cand_legal_s;
  logic [Q_W-1:0]         cmp_max_s;
  logic [ACT_W-1:0]       cmp_idx_s;

  // cmp_vld_q/cmp_idx_q trail the read strobe by one cycle to line up with rd_data.
  assign cand_legal_s = cmp_vld_q & mask_q[cmp_idx_q];

  q_max_cmp u_cmp (
    .run_max_i    (run_max_q),
    .run_idx_i    (run_idx_q),
    .cand_val_i   (rd_data),
    .cand_idx_i   (cmp_idx_q),
    .cand_legal_i (cand_legal_s),
    .new_max_o    (cmp_max_s),
    .new_idx_o    (cmp_idx_s)
  );

  // Next-state logic for the scan FSM, read port, running max and results.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    k_d       = k_q;
    rd_en_d   = rd_en_q;
    rd_addr_d = rd_addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cmp_vld_d = rd_en_q;
    cmp_idx_d = k_q;
    run_max_d = run_max_q;
    run_idx_d = run_idx_q;
    res_max_d = res_max_q;
    res_idx_d = res_idx_q;
    res_nl_d  = res_nl_q;

    if (cmp_vld_q) begin
      run_max_d = cmp_max_s;
      run_idx_d = cmp_idx_s;
    end else begin
      run_max_d = run_max_q;
      run_idx_d = run_idx_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d    = legal_mask;
          k_d       = 4'd0;
          rd_en_d   = 1'b1;
          rd_addr_d = state_base;
          busy_d    = 1'b1;
          run_max_d = 8'd0;
          run_idx_d = NO_ACTION;
          state_d   = ST_SCAN;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (k_q == LAST_ACTION) begin
          rd_en_d = 1'b0;
          state_d = ST_DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + 10'd1;
          k_d       = k_q + 4'd1;
        end
      end
      ST_DRAIN: begin
        // Results take the compare output so the final read is included.
        res_max_d = cmp_max_s;
        res_idx_d = cmp_idx_s;
        res_nl_d  = (mask_q == 9'd0);
        done_d    = 1'b1;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        rd_en_d = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any scan in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mask_q    <= 9'd0;
      k_q       <= 4'd0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= 10'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cmp_vld_q <= 1'b0;
      cmp_idx_q <= 4'd0;
      run_max_q <= 8'd0;
      run_idx_q <= NO_ACTION;
      res_max_q <= 8'd0;
      res_idx_q <= NO_ACTION;
      res_nl_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      k_q       <= k_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cmp_vld_q <= cmp_vld_d;
      cmp_idx_q <= cmp_idx_d;
      run_max_q <= run_max_d;
      run_idx_q <= run_idx_d;
      res_max_q <= res_max_d;
      res_idx_q <= res_idx_d;
      res_nl_q  <= res_nl_d;
    end
  end

  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign max_Q       = res_max_q;
  assign best_action = res_idx_q;
  assign no_legal    = res_nl_q;

endmodule

// File: doc/q_max_scanner.md
Name: q_max_scanner

Overview:
- Upstream feeder of the Q-value update stage in the tic-tac-toe Q-learning datapath.
- On a start pulse it scans the Q-table row for the next board state, one action per cell 0..8, masking out occupied cells.
- Produces max_Q (the max over the legal next actions) and its argmax, used for greedy move selection.
- max_Q drives the update stage's max_Q input directly; unsigned 8-bit, same as that stage.

Parameters:
N_ACTIONS, 9, number of actions per state (board cells), index width 4
Q_W, 8, Q-value width, unsigned
ADDR_W, 10, Q-table address width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a scan; sampled only in IDLE
state_base  input  ADDR_W  Q-table address of action 0 for the next state
legal_mask  input  N_ACTIONS  bit i=1 means cell i is empty (legal)
rd_en  output  1  Q-table read strobe
rd_addr  output  ADDR_W  Q-table read address
rd_data  input  Q_W  Q-table read data, valid exactly 1 cycle after rd_en
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse; results valid from this cycle
max_Q  output  Q_W  max Q over legal actions, or 0 if none legal
best_action  output  4  index of max, or 4'hF if none legal
no_legal  output  1  legal_mask was all zero (terminal state)

Behaviour:
- Reset (async assert, sync deassert is system-level): state=IDLE; rd_en=0, rd_addr=0, busy=0, done=0, max_Q=0, best_action=4'hF, no_legal=0. The scan index and the running max clear.
- Reset mid-scan aborts immediately with no done pulse. Outputs take their reset values.
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE: start=1 at edge T latches state_base and legal_mask. Running max clears to 0 and running index to 4'hF. Go to SCAN.
- SCAN (cycles T+1..T+N_ACTIONS): rd_en=1, rd_addr=base+k for k=0..N_ACTIONS-1 in order. After k=N_ACTIONS-1 go to DRAIN.
  - All N_ACTIONS reads are issued regardless of mask, so latency is fixed.
- Read-data compare (T+2..T+N_ACTIONS+1): the data for cell k is considered only if mask bit k=1.
  - Update when running index is 4'hF (first legal) OR rd_data > running max (strict, unsigned).
  - Tie rule: the lowest index wins.
- DRAIN (one cycle, T+N_ACTIONS+1): rd_en=0. Captures the final read.
- DONE (T+N_ACTIONS+2): done=1 for exactly one cycle. max_Q/best_action/no_legal are registered from the running values. Return to IDLE.
- Latency: start edge to done = N_ACTIONS+2 cycles (11 at default).
- busy=1 in SCAN, DRAIN and DONE; 0 in IDLE.
- start while busy is ignored, with no queueing. start held high in the cycle done is asserted is also ignored. start may be accepted the cycle after done.
- Outputs hold their last result until the next DONE. They do not change during a scan.
- All-zero legal_mask: max_Q=0, best_action=4'hF, no_legal=1. Reads are still issued.
- A legal cell with Q=0 gives best_action=that index, max_Q=0, no_legal=0.
- Address arithmetic: base+k wraps modulo 2^ADDR_W. No overflow flag.
- Q values are unsigned, and 8'hFF is a valid maximum.

Decomposition:
- Package q_learn_pkg:
  - constants Q_W, N_ACTIONS, ACT_W=4, NO_ACTION=4'hF
  - enum typedef for the FSM states
  - q_val_t (Q_W-bit unsigned) type; shared with the update stage
- Sub-module q_max_cmp: combinational compare-select of {running max, running index} against {rd_data, k, mask bit}. It applies the first-legal and strict-greater rules and is reused by the later epsilon-greedy selector.

Test Plan:
1. Reset mid-scan: assert rst_n=0 at T+5 -> no done pulse, busy=0, max_Q=0, best_action=F. A following scan completes normally.
2. Basic scan: mask=9'h1FF, Q row {5,2,9,1,0,3,9,4,7} -> done at T+11, max_Q=9, best_action=2 (tie with 6 resolved to the lowest index), rd_addr sequence base..base+8.
3. Masked maximum: same row, mask=9'b1_1011_1011 (cells 2 and 6 illegal) -> max_Q=7, best_action=8.
4. Terminal state: mask=0 -> max_Q=0, best_action=F, no_legal=1, done at T+11.
5. Edge values: only cell 4 legal with Q=8'hFF -> max_Q=255, best_action=4. Only cell 0 legal with Q=0 -> max_Q=0, best_action=0, no_legal=0.
6. Handshake and wrap: start pulses at T+3 and at the done cycle are ignored. Back-to-back start at done+1 is accepted. state_base=10'h3FC gives rd_addr 3FC,3FD,3FE,3FF,000..004.
